y_symbol_tx: RTL and testbench
==============================

Name: y_symbol_tx

Overview:
- Transmit side of the 2-bit Y symbol stream consumed by the fsm block.
- Captures a packed word of up to NSYM 2-bit symbols on a start request.
- Emits the symbols LSB-first, one per clock, on Y with a valid flag and stall input, so benches and upstream logic drive the FSM deterministically instead of with hand-timed delays.
- Sits between a sequence source (bench or controller) and the fsm Y input.

Parameters:
- NSYM, 8, maximum symbols per burst (1..15).
- SW, 2, symbol width in bits.
- IDLE_SYM, 2'b00, value driven on Y whenever y_valid=0 and no symbol is held.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset; sampled on posedge clk.
- start  input  1  request to load sym_word/sym_count; honoured only when not busy.
- sym_word  input  NSYM*SW  packed symbols; symbol k = sym_word[k*SW +: SW], symbol 0 sent first.
- sym_count  input  4  number of symbols to send (0..NSYM); values >NSYM clamp to NSYM.
- pause  input  1  stall: current Y symbol is not consumed at a posedge where pause=1.
- Y  output  SW  current symbol.
- y_valid  output  1  Y carries a live symbol.
- sym_idx  output  4  index of the symbol currently on Y (0 when idle).
- busy  output  1  burst in progress (state SEND).
- done  output  1  one-cycle pulse after the last symbol is consumed, or after a zero-length start.

Behaviour:
- All outputs are registered. Reset values: Y=IDLE_SYM, y_valid=0, sym_idx=0, busy=0, done=0, state=IDLE.
- Reset has priority over every other input, including mid-burst; the burst is discarded and no done pulse is produced.
- States: IDLE, SEND.
- IDLE, posedge with start=1 and sym_count>=1:
  - capture sym_word and the clamped count; state<=SEND.
  - Next cycle: Y=symbol 0, y_valid=1, sym_idx=0, busy=1.
  - Latency from start sampled to first valid symbol is 1 cycle.
- IDLE, posedge with start=1 and sym_count=0: stay IDLE; next cycle done=1, y_valid=0.
- IDLE, start=0: outputs hold idle values; done clears to 0.
- SEND, posedge with pause=1: Y, y_valid, sym_idx and the captured word all hold; done stays 0.
- SEND, posedge with pause=0 and sym_idx < count-1: sym_idx+1; Y=next symbol; y_valid stays 1.
- SEND, posedge with pause=0 and sym_idx = count-1:
  - state<=IDLE; next cycle Y=IDLE_SYM, y_valid=0, sym_idx=0, busy=0, done=1 for exactly one cycle.
- start while busy: ignored; the captured word is not disturbed. Changes to sym_word/sym_count while busy have no effect.
- start in the done cycle (state already IDLE): accepted. First symbol of the new burst appears in the following cycle and done drops. Back-to-back bursts therefore have a 1-cycle gap with y_valid=0.
- pause is ignored in IDLE.
- Single-symbol burst (count=1): exactly one y_valid cycle (plus any pause cycles), then done.
- Full burst (count=NSYM): sym_idx reaches NSYM-1, then returns to 0; there is no wrap into a second pass.
- Throughput without pause is one symbol per clock. Burst length in cycles is count + number of pause-high posedges in SEND.

Test Plan:
- Reset, then start with sym_word=16'h00E4, sym_count=4 -> on 4 consecutive cycles Y=0,1,2,3 with y_valid=1 and sym_idx=0..3; next cycle y_valid=0, Y=0, done=1 for one cycle; busy high for exactly 4 cycles.
- Same burst with pause=1 for 2 cycles while Y=2 -> Y=2 held for 3 cycles with y_valid=1 and sym_idx=2; then Y=3, then done; busy high 6 cycles.
- start with sym_count=0 -> y_valid never asserts, busy stays 0, done=1 exactly one cycle after start. start with sym_count=12 -> 8 symbols emitted (clamped).
- start re-asserted mid-burst with a different sym_word=16'hFFFF -> original symbols continue unchanged; start asserted in the done cycle with sym_word=16'h0003, count=1 -> Y=3 valid for one cycle, then second done pulse.
- reset asserted while sym_idx=2 of an 8-symbol burst -> next cycle Y=0, y_valid=0, busy=0, done=0, sym_idx=0; no done pulse follows.
- Drive the fsm Y input from this block with word 16'hE8E4, count 8 -> fsm State trace matches the trace produced by applying the same symbol list directly, one symbol per clock.

Source files
------------

// File: rtl/y_symbol_tx.sv
// Y symbol transmitter: captures a packed burst of up to NSYM symbols and
// emits them LSB-first, one per clock, with valid/stall handshake and done pulse.
module y_symbol_tx #(
   parameter int unsigned      NSYM     = 8,
   parameter int unsigned      SW       = 2,
   parameter logic [SW-1:0]    IDLE_SYM = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [NSYM*SW-1:0]  sym_word,
   input  logic [3:0]          sym_count,
   input  logic                pause,
   output logic [SW-1:0]       Y,
   output logic                y_valid,
   output logic [3:0]          sym_idx,
   output logic                busy,
   output logic                done
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   localparam logic [3:0] MAX_COUNT = 4'(NSYM);

   state_t               state;
   logic [NSYM*SW-1:0]   pend;
   logic [3:0]           count_q;
   logic [3:0]           count_clamped;
   logic                 last_sym;

   always_comb begin
      count_clamped = (sym_count > MAX_COUNT) ? MAX_COUNT : sym_count;
      last_sym      = ((sym_idx + 4'd1) == count_q);
   end

   // pend holds the not-yet-emitted symbols; the next one is always in its low SW bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         pend    <= '0;
         count_q <= '0;
         Y       <= IDLE_SYM;
         y_valid <= 1'b0;
         sym_idx <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               Y       <= IDLE_SYM;
               y_valid <= 1'b0;
               sym_idx <= '0;
               busy    <= 1'b0;
               done    <= 1'b0;
               if (start) begin
                  if (count_clamped != 4'd0) begin
                     state   <= SEND;
                     pend    <= sym_word >> SW;
                     count_q <= count_clamped;
                     Y       <= sym_word[SW-1:0];
                     y_valid <= 1'b1;
                     busy    <= 1'b1;
                  end else begin
                     done    <= 1'b1;
                  end
               end
            end
            SEND: begin
               done <= 1'b0;
               if (!pause) begin
                  if (last_sym) begin
                     state   <= IDLE;
                     Y       <= IDLE_SYM;
                     y_valid <= 1'b0;
                     sym_idx <= '0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     sym_idx <= sym_idx + 4'd1;
                     Y       <= pend[SW-1:0];
                     pend    <= pend >> SW;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_y_symbol_tx.sv
// Bench for y_symbol_tx: directed and random bursts checked cycle by cycle
// against an expected transcript built from the burst rules.
module tb_y_symbol_tx;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] sym_word;
   logic [3:0]  sym_count;
   logic        pause;
   logic [1:0]  Y;
   logic        y_valid;
   logic [3:0]  sym_idx;
   logic        busy;
   logic        done;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic [1:0] y;
      logic       v;
      logic [3:0] idx;
      logic       b;
      logic       d;
      logic       p;
   } exp_t;

   y_symbol_tx #(.NSYM(8), .SW(2), .IDLE_SYM(2'b00)) dut (
      .clk(clk), .reset(reset), .start(start), .sym_word(sym_word),
      .sym_count(sym_count), .pause(pause), .Y(Y), .y_valid(y_valid),
      .sym_idx(sym_idx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input exp_t e);
      chk({tag, ".Y"},       32'(Y),       32'(e.y));
      chk({tag, ".y_valid"}, 32'(y_valid), 32'(e.v));
      chk({tag, ".sym_idx"}, 32'(sym_idx), 32'(e.idx));
      chk({tag, ".busy"},    32'(busy),    32'(e.b));
      chk({tag, ".done"},    32'(done),    32'(e.d));
   endtask

   // Called at a negedge with outputs already checked; returns at the negedge
   // of the done cycle with start low. pz holds a 2-bit pause count per symbol.
   task automatic run_burst(input string tag, input logic [15:0] word,
                            input logic [3:0] count, input logic [15:0] pz,
                            input bit noisy);
      exp_t q[$];
      exp_t e;
      int   n;
      int   pk;
      n = (count > 4'd8) ? 8 : int'(count);
      for (int k = 0; k < n; k++) begin
         pk = int'((pz >> (2 * k)) & 16'd3);
         for (int r = 0; r <= pk; r++) begin
            e.y   = 2'((word >> (2 * k)) & 16'd3);
            e.v   = 1'b1;
            e.idx = 4'(k);
            e.b   = 1'b1;
            e.d   = 1'b0;
            e.p   = (r < pk);
            q.push_back(e);
         end
      end
      e = '{y: 2'b00, v: 1'b0, idx: 4'd0, b: 1'b0, d: 1'b1, p: 1'b0};
      q.push_back(e);

      start     = 1'b1;
      sym_word  = word;
      sym_count = count;
      pause     = 1'($urandom_range(0, 1));
      foreach (q[j]) begin
         @(negedge clk);
         chk_out($sformatf("%s[%0d]", tag, j), q[j]);
         if (j == q.size() - 1) begin
            start = 1'b0;
            pause = 1'($urandom_range(0, 1));
         end else begin
            pause = q[j].p;
            if (noisy) begin
               start     = 1'($urandom_range(0, 1)) | (j == 1);
               sym_word  = (j == 1) ? 16'hFFFF : 16'($urandom);
               sym_count = 4'($urandom);
            end else begin
               start = 1'b0;
            end
         end
      end
   endtask

   task automatic idle_chk(input string tag, input int n);
      exp_t e;
      e = '{y: 2'b00, v: 1'b0, idx: 4'd0, b: 1'b0, d: 1'b0, p: 1'b0};
      for (int i = 0; i < n; i++) begin
         start = 1'b0;
         pause = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk_out($sformatf("%s[%0d]", tag, i), e);
      end
   endtask

   initial begin
      exp_t        zero;
      logic [15:0] w;
      logic [15:0] pz;
      logic [3:0]  c;
      zero = '{y: 2'b00, v: 1'b0, idx: 4'd0, b: 1'b0, d: 1'b0, p: 1'b0};

      reset = 1'b1; start = 1'b1; pause = 1'b0; sym_word = 16'h00E4; sym_count = 4'd4;
      repeat (3) @(negedge clk);
      chk_out("reset", zero);
      reset = 1'b0; start = 1'b0;
      idle_chk("idle0", 2);

      run_burst("e4", 16'h00E4, 4'd4, 16'h0000, 1'b0);
      idle_chk("gap1", 1);
      run_burst("e4_pause", 16'h00E4, 4'd4, 16'h0020, 1'b0);
      idle_chk("gap2", 1);
      run_burst("zero_len", 16'hABCD, 4'd0, 16'h0000, 1'b0);
      idle_chk("gap3", 1);
      run_burst("clamp12", 16'h9C3B, 4'd12, 16'h0000, 1'b0);
      idle_chk("gap4", 1);
      run_burst("clamp15", 16'h5A0F, 4'd15, 16'h1234, 1'b0);
      idle_chk("gap5", 1);
      run_burst("noisy", 16'h00E4, 4'd4, 16'h0000, 1'b1);
      run_burst("chain", 16'h0003, 4'd1, 16'h0000, 1'b0);
      idle_chk("gap6", 2);
      run_burst("e8e4", 16'hE8E4, 4'd8, 16'h0000, 1'b0);
      run_burst("full_chain", 16'h1B6C, 4'd8, 16'h0000, 1'b0);
      idle_chk("gap7", 1);

      // Reset mid-burst at sym_idx=2 discards the burst without a done pulse.
      start = 1'b1; sym_word = 16'h7531; sym_count = 4'd8; pause = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         start = 1'b0;
         chk($sformatf("rst_burst.idx%0d", k), 32'(sym_idx), 32'(k));
         chk($sformatf("rst_burst.Y%0d", k), 32'(Y), 32'((16'h7531 >> (2 * k)) & 16'd3));
      end
      reset = 1'b1;
      @(negedge clk);
      chk_out("rst_mid", zero);
      reset = 1'b0;
      idle_chk("post_rst", 3);

      for (int t = 0; t < 40; t++) begin
         w  = 16'($urandom);
         c  = 4'($urandom_range(0, 15));
         pz = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0000;
         run_burst($sformatf("rnd%0d", t), w, c, pz, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) idle_chk($sformatf("rgap%0d", t), int'($urandom_range(1, 3)));
      end
      idle_chk("tail", 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
